alu_exec_ctrl: RTL and testbench



---
 rtl/alu_exec_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Q1-Q4 instruction sequencer for the PIC16C5x ALU; owns W and the {Z, DC, C} status bits.
// Optional feature macro: ALU_EXEC_OVERLAP_EN (accept the next instruction during Q4).
`ifndef ALU_DATA_WIDTH
`define ALU_DATA_WIDTH 8
`endif
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 5
`endif
`ifndef ALU_STATUS_WIDTH
`define ALU_STATUS_WIDTH 3
`endif

module alu_exec_ctrl (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           instr_valid,
    input  logic [11:0]                    instr,
    output logic                           instr_ready,
    output logic                           illegal,
    output logic [4:0]                     f_addr,
    input  logic [`ALU_DATA_WIDTH-1:0]     f_rdata,
    output logic                           f_we,
    output logic [`ALU_DATA_WIDTH-1:0]     f_wdata,
    output logic [`ALU_DATA_WIDTH-1:0]     alu_w,
    output logic [`ALU_DATA_WIDTH-1:0]     alu_f,
    output logic [`ALU_DATA_WIDTH-1:0]     alu_l,
    output logic [`ALU_FUNC_WIDTH-1:0]     alu_func,
    output logic [2:0]                     alu_bitsel,
    output logic                           alu_cflag,
    output logic                           alu_en,
    output logic [`ALU_STATUS_WIDTH-1:0]   alu_status_in,
    input  logic [`ALU_DATA_WIDTH-1:0]     alu_result,
    input  logic [`ALU_STATUS_WIDTH-1:0]   alu_status,
    output logic [`ALU_DATA_WIDTH-1:0]     w_reg,
    output logic [`ALU_STATUS_WIDTH-1:0]   status_reg
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] Q1   = 3'd1;
    localparam logic [2:0] Q2   = 3'd2;
    localparam logic [2:0] Q3   = 3'd3;
    localparam logic [2:0] Q4   = 3'd4;

    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_ADDWF = `ALU_FUNC_WIDTH'(0);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_SUBWF = `ALU_FUNC_WIDTH'(1);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_ANDWF = `ALU_FUNC_WIDTH'(2);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_IORWF = `ALU_FUNC_WIDTH'(3);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_XORWF = `ALU_FUNC_WIDTH'(4);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_COMF  = `ALU_FUNC_WIDTH'(5);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_DECF  = `ALU_FUNC_WIDTH'(6);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_INCF  = `ALU_FUNC_WIDTH'(7);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_MOVF  = `ALU_FUNC_WIDTH'(8);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_RLF   = `ALU_FUNC_WIDTH'(9);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_RRF   = `ALU_FUNC_WIDTH'(10);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_SWAPF = `ALU_FUNC_WIDTH'(11);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_BCF   = `ALU_FUNC_WIDTH'(12);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_BSF   = `ALU_FUNC_WIDTH'(13);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_ANDLW = `ALU_FUNC_WIDTH'(14);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_IORLW = `ALU_FUNC_WIDTH'(15);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_XORLW = `ALU_FUNC_WIDTH'(16);
    localparam logic [`ALU_FUNC_WIDTH-1:0] ALU_NOP   = `ALU_FUNC_WIDTH'(17);

    localparam logic [2:0] MASK_ALL = 3'b111;
    localparam logic [2:0] MASK_Z   = 3'b100;
    localparam logic [2:0] MASK_C   = 3'b001;

    logic [2:0]                   stateReg, stateNext;
    logic                         accept, readyNext;
    logic [`ALU_FUNC_WIDTH-1:0]   decFunc;
    logic [`ALU_DATA_WIDTH-1:0]   decLit;
    logic                         decWriteF, decWriteW, decZeroW, decIllegal, byteOp;
    logic [2:0]                   decMask;
    logic                         writeFReg, writeWReg;
    logic [2:0]                   maskReg, capStatus, statusMerged, statusNext;
    logic [`ALU_DATA_WIDTH-1:0]   wNext;

    assign accept = instr_valid && instr_ready;

    always_comb begin
        stateNext = IDLE;
        case (stateReg)
            IDLE:    stateNext = accept ? Q1 : IDLE;
            Q1:      stateNext = Q2;
            Q2:      stateNext = Q3;
            Q3:      stateNext = Q4;
            Q4:      stateNext = accept ? Q1 : IDLE;
            default: stateNext = IDLE;
        endcase
    end

`ifdef ALU_EXEC_OVERLAP_EN
    assign readyNext = (stateNext == IDLE) || (stateNext == Q4);
`else
    assign readyNext = (stateNext == IDLE);
`endif

    // Pseudo-ops reuse literal functions: CLRF/CLRW = AND with 0, MOVWF/MOVLW = IOR with 0.
    always_comb begin
        decFunc    = ALU_NOP;
        decLit     = '0;
        decWriteF  = 1'b0;
        decWriteW  = 1'b0;
        decZeroW   = 1'b0;
        decIllegal = 1'b0;
        decMask    = 3'b000;
        byteOp     = 1'b0;
        if (instr[11:10] == 2'b11) begin
            decLit    = instr[7:0];
            decWriteW = 1'b1;
            case (instr[9:8])
                2'b00:   begin decFunc = ALU_IORLW; decZeroW = 1'b1; end
                2'b01:   begin decFunc = ALU_IORLW; decMask = MASK_Z; end
                2'b10:   begin decFunc = ALU_ANDLW; decMask = MASK_Z; end
                default: begin decFunc = ALU_XORLW; decMask = MASK_Z; end
            endcase
        end else if (instr[11:9] == 3'b010) begin
            decFunc   = instr[8] ? ALU_BSF : ALU_BCF;
            decWriteF = 1'b1;
        end else if (instr[11:6] == 6'b000000) begin
            if (instr[5]) begin
                decFunc   = ALU_IORLW;
                decWriteF = 1'b1;
            end else if (instr[4:0] != 5'd0) begin
                decIllegal = 1'b1;
            end
        end else if (instr[11:6] == 6'b000001) begin
            if (instr[5] || instr[4:0] == 5'd0) begin
                decFunc   = ALU_ANDLW;
                decMask   = MASK_Z;
                decWriteF = instr[5];
                decWriteW = !instr[5];
            end else begin
                decIllegal = 1'b1;
            end
        end else if (instr[11:10] == 2'b00) begin
            byteOp = 1'b1;
            case (instr[11:6])
                6'b000111: begin decFunc = ALU_ADDWF; decMask = MASK_ALL; end
                6'b000010: begin decFunc = ALU_SUBWF; decMask = MASK_ALL; end
                6'b000101: begin decFunc = ALU_ANDWF; decMask = MASK_Z; end
                6'b000100: begin decFunc = ALU_IORWF; decMask = MASK_Z; end
                6'b000110: begin decFunc = ALU_XORWF; decMask = MASK_Z; end
                6'b001001: begin decFunc = ALU_COMF;  decMask = MASK_Z; end
                6'b000011: begin decFunc = ALU_DECF;  decMask = MASK_Z; end
                6'b001010: begin decFunc = ALU_INCF;  decMask = MASK_Z; end
                6'b001000: begin decFunc = ALU_MOVF;  decMask = MASK_Z; end
                6'b001101: begin decFunc = ALU_RLF;   decMask = MASK_C; end
                6'b001100: begin decFunc = ALU_RRF;   decMask = MASK_C; end
                6'b001110: begin decFunc = ALU_SWAPF; end
                default:   begin byteOp = 1'b0; decIllegal = 1'b1; end
            endcase
            decWriteF = byteOp && instr[5];
            decWriteW = byteOp && !instr[5];
        end else begin
            decIllegal = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < `ALU_STATUS_WIDTH; gi = gi + 1) begin : g_status_merge
            assign statusMerged[gi] = maskReg[gi] ? capStatus[gi] : status_reg[gi];
        end
    endgenerate

    // f_wdata doubles as the captured result that feeds W at the end of Q4.
    assign wNext      = (stateReg == Q4 && writeWReg) ? f_wdata : w_reg;
    assign statusNext = (stateReg == Q4) ? statusMerged : status_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg      <= IDLE;
            instr_ready   <= 1'b1;
            illegal       <= 1'b0;
            f_addr        <= '0;
            f_we          <= 1'b0;
            f_wdata       <= '0;
            alu_w         <= '0;
            alu_f         <= '0;
            alu_l         <= '0;
            alu_func      <= '0;
            alu_bitsel    <= '0;
            alu_cflag     <= 1'b0;
            alu_en        <= 1'b0;
            alu_status_in <= '0;
            w_reg         <= '0;
            status_reg    <= '0;
            writeFReg     <= 1'b0;
            writeWReg     <= 1'b0;
            maskReg       <= '0;
            capStatus     <= '0;
        end else begin
            stateReg    <= stateNext;
            instr_ready <= readyNext;
            illegal     <= accept && decIllegal;
            alu_en      <= (stateReg == Q2);
            f_we        <= (stateReg == Q3) && writeFReg;
            w_reg       <= wNext;
            status_reg  <= statusNext;
            if (stateReg == Q2) begin
                alu_f <= f_rdata;
            end
            if (stateReg == Q3) begin
                f_wdata   <= alu_result;
                capStatus <= alu_status;
            end
            if (accept) begin
                f_addr        <= instr[4:0];
                alu_func      <= decFunc;
                alu_l         <= decLit;
                alu_bitsel    <= instr[7:5];
                alu_w         <= decZeroW ? '0 : wNext;
                alu_cflag     <= statusNext[0];
                alu_status_in <= statusNext;
                writeFReg     <= decWriteF;
                writeWReg     <= decWriteW;
                maskReg       <= decMask;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: external ALU and register file models plus a PIC-level reference.
module tb_alu_exec_ctrl;
    logic        clk, rst_n, instr_valid;
    logic [11:0] instr;
    logic        instr_ready, illegal, f_we, alu_cflag, alu_en;
    logic [4:0]  f_addr;
    logic [7:0]  f_rdata, f_wdata, alu_w, alu_f, alu_l, alu_result, w_reg;
    logic [4:0]  alu_func;
    logic [2:0]  alu_bitsel, alu_status_in, alu_status, status_reg;

    alu_exec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .illegal(illegal), .f_addr(f_addr), .f_rdata(f_rdata),
        .f_we(f_we), .f_wdata(f_wdata), .alu_w(alu_w), .alu_f(alu_f), .alu_l(alu_l),
        .alu_func(alu_func), .alu_bitsel(alu_bitsel), .alu_cflag(alu_cflag), .alu_en(alu_en),
        .alu_status_in(alu_status_in), .alu_result(alu_result), .alu_status(alu_status),
        .w_reg(w_reg), .status_reg(status_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [11:0] ins;
        logic        ill;
        logic        we;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  w;
        logic [2:0]  st;
        int          acc;
    } expT;

    expT        sbq[$];
    expT        cur;
    logic [7:0] rf   [32];
    logic [7:0] mMem [32];
    logic [7:0] mW;
    logic [2:0] mSt;
    int checks = 0, failures = 0, cyc = 0, lastAccept = 0, strayWe = 0, illSeen = 0;
    bit pendQ4 = 0, pendWb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // External ALU: bits an op does not define come back inverted so a wrong mask is visible.
    function automatic logic [10:0] aluModel(input logic [4:0] fn, input logic [7:0] w, f, l,
                                             input logic [2:0] b, input logic cin,
                                             input logic [2:0] sin);
        logic [7:0] r;
        logic [8:0] s;
        logic [4:0] h;
        logic [2:0] st;
        r  = 8'hA5;
        st = ~sin;
        s  = {1'b0, f} + {1'b0, w};
        h  = {1'b0, f[3:0]} + {1'b0, w[3:0]};
        case (fn)
            5'd0:  begin r = s[7:0]; st[0] = s[8]; st[1] = h[4]; end
            5'd1:  begin r = f - w; st[0] = (f >= w); st[1] = (f[3:0] >= w[3:0]); end
            5'd2:  r = f & w;
            5'd3:  r = f | w;
            5'd4:  r = f ^ w;
            5'd5:  r = ~f;
            5'd6:  r = f - 8'd1;
            5'd7:  r = f + 8'd1;
            5'd8:  r = f;
            5'd9:  begin r = {f[6:0], cin}; st[0] = f[7]; end
            5'd10: begin r = {cin, f[7:1]}; st[0] = f[0]; end
            5'd11: r = {f[3:0], f[7:4]};
            5'd12: r = f & ~(8'd1 << b);
            5'd13: r = f | (8'd1 << b);
            5'd14: r = w & l;
            5'd15: r = w | l;
            5'd16: r = w ^ l;
            default: ;
        endcase
        st[2] = (r == 8'd0);
        return {st, r};
    endfunction

    assign {alu_status, alu_result} = aluModel(alu_func, alu_w, alu_f, alu_l, alu_bitsel,
                                               alu_cflag, alu_status_in);
    assign f_rdata = rf[f_addr];

    // Architectural effect of one PIC16C5x instruction on W, status and the file.
    function automatic expT refModel(input logic [11:0] ins, input logic [7:0] w,
                                     input logic [2:0] st, input logic [7:0] fv);
        expT r;
        logic z, dc, c, legal;
        logic [7:0] res, k;
        logic [8:0] sum;
        logic [4:0] half;
        r.ins = ins; r.ill = 1'b0; r.we = 1'b0; r.addr = ins[4:0]; r.wdata = 8'h00;
        r.w = w; r.acc = 0;
        z = st[2]; dc = st[1]; c = st[0];
        k = ins[7:0]; res = 8'h00; legal = 1'b1;
        sum  = {1'b0, fv} + {1'b0, w};
        half = {1'b0, fv[3:0]} + {1'b0, w[3:0]};
        if (ins == 12'h000) begin
        end else if (ins[11:5] == 7'b0000001) begin r.we = 1'b1; r.wdata = w; end
        else if (ins == 12'h040) begin r.w = 8'h00; z = 1'b1; end
        else if (ins[11:5] == 7'b0000011) begin r.we = 1'b1; z = 1'b1; end
        else if (ins[11:8] == 4'hC) r.w = k;
        else if (ins[11:8] == 4'hD) begin r.w = w | k; z = (r.w == 8'h00); end
        else if (ins[11:8] == 4'hE) begin r.w = w & k; z = (r.w == 8'h00); end
        else if (ins[11:8] == 4'hF) begin r.w = w ^ k; z = (r.w == 8'h00); end
        else if (ins[11:8] == 4'h4) begin r.we = 1'b1; r.wdata = fv & ~(8'd1 << ins[7:5]); end
        else if (ins[11:8] == 4'h5) begin r.we = 1'b1; r.wdata = fv | (8'd1 << ins[7:5]); end
        else if (ins[11:10] == 2'b00) begin
            case (ins[11:6])
                6'h07: begin res = sum[7:0]; c = sum[8]; dc = half[4]; end
                6'h02: begin res = fv - w; c = (fv >= w); dc = (fv[3:0] >= w[3:0]); end
                6'h05: res = fv & w;
                6'h04: res = fv | w;
                6'h06: res = fv ^ w;
                6'h09: res = ~fv;
                6'h03: res = fv - 8'd1;
                6'h0A: res = fv + 8'd1;
                6'h08: res = fv;
                6'h0D: begin res = {fv[6:0], c}; c = fv[7]; end
                6'h0C: begin res = {c, fv[7:1]}; c = fv[0]; end
                6'h0E: res = {fv[3:0], fv[7:4]};
                default: legal = 1'b0;
            endcase
            if (legal && ins[11:6] != 6'h0D && ins[11:6] != 6'h0C && ins[11:6] != 6'h0E)
                z = (res == 8'h00);
            if (!legal) r.ill = 1'b1;
            else if (ins[5]) begin r.we = 1'b1; r.wdata = res; end
            else r.w = res;
        end else begin
            r.ill = 1'b1;
        end
        r.st = {z, dc, c};
        return r;
    endfunction

    // Register file write and instruction accept: the model runs in program order.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && f_we) rf[f_addr] = f_wdata;
            if (rst_n && instr_valid && instr_ready) begin
                e = refModel(instr, mW, mSt, mMem[instr[4:0]]);
                e.acc = cyc;
                lastAccept = cyc;
                mW = e.w;
                mSt = e.st;
                if (e.we) mMem[e.addr] = e.wdata;
                sbq.push_back(e);
            end
        end
    end

    // Monitor: the cycle after alu_en is Q4; W and status are checked one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq.delete();
                pendQ4 = 0; pendWb = 0; illSeen = 0;
            end else begin
                if (illegal) illSeen++;
                if (pendWb) begin
                    chk("w_reg", 32'(w_reg), 32'(cur.w));
                    chk("status_reg", 32'(status_reg), 32'(cur.st));
                    $display("txn ins=%03h ill=%0d we=%0d w=%02h st=%b", cur.ins, cur.ill,
                             cur.we, w_reg, status_reg);
                    pendWb = 0;
                end
                if (pendQ4) begin
                    pendQ4 = 0;
                    if (sbq.size() == 0) begin
                        chk("scoreboard_empty_at_q4", 32'(1), 32'(0));
                    end else begin
                        cur = sbq.pop_front();
                        chk("q4_latency", 32'(cyc - cur.acc), 32'(3));
                        chk("alu_en_one_cycle", 32'(alu_en), 32'(0));
                        chk("f_we", 32'(f_we), 32'(cur.we));
                        if (cur.we) begin
                            chk("f_wdata", 32'(f_wdata), 32'(cur.wdata));
                            chk("f_addr", 32'(f_addr), 32'(cur.addr));
                        end
                        chk("illegal_pulses", 32'(illSeen), 32'(cur.ill));
                        illSeen = 0;
                        pendWb = 1;
                    end
                end else if (f_we) begin
                    strayWe++;
                end
                if (alu_en) pendQ4 = 1;
            end
        end
    end

    task automatic issue(input logic [11:0] ins);
        int t = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = ins;
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'(1), 32'(0));
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int t = 0;
        while ((sbq.size() != 0 || pendQ4 || pendWb) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("drain_timeout", 32'(1), 32'(0));
        @(negedge clk);
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] v);
        rf[a] = v;
        mMem[a] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[4];
        int t;
        int spacing;
        logic [7:0] saved;
        rst_n = 1'b1; instr_valid = 1'b0; instr = 12'h000;
        mW = 8'h00; mSt = 3'b000;
        for (int i = 0; i < 32; i++) preload(5'(i), 8'($urandom));
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'(1));
        chk("rst_w_reg", 32'(w_reg), 32'(0));
        chk("rst_status", 32'(status_reg), 32'(0));
        chk("rst_f_we", 32'(f_we), 32'(0));
        chk("rst_alu_en", 32'(alu_en), 32'(0));
        chk("rst_illegal", 32'(illegal), 32'(0));
        chk("rst_f_addr", 32'(f_addr), 32'(0));
        rst_n = 1'b1;

        issue(12'hC3C);
        waitIdle();
        chk("movlw_w", 32'(w_reg), 32'h3C);
        chk("movlw_status", 32'(status_reg), 32'(0));
        issue(12'hC0F);
        waitIdle();
        preload(5'h10, 8'hF1);
        issue(12'h1F0);
        waitIdle();
        chk("addwf_file", 32'(rf[16]), 32'h00);
        chk("addwf_status", 32'(status_reg), 32'b111);
        chk("addwf_w_kept", 32'(w_reg), 32'h0F);
        preload(5'h08, 8'h80);
        issue(12'h348);
        waitIdle();
        chk("rlf_w", 32'(w_reg), 32'h01);
        chk("rlf_status", 32'(status_reg), 32'b111);
        preload(5'h0A, 8'h01);
        issue(12'h5EA);
        issue(12'hA05);
        waitIdle();
        chk("bsf_file", 32'(rf[10]), 32'h81);
        chk("bsf_status", 32'(status_reg), 32'b111);

        for (int n = 0; n < 200; n++) begin
            issue(12'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        waitIdle();

        issue(12'hC11); acc[0] = lastAccept;
        issue(12'h1F3); acc[1] = lastAccept;
        issue(12'h213); acc[2] = lastAccept;
        issue(12'h033); acc[3] = lastAccept;
`ifdef ALU_EXEC_OVERLAP_EN
        spacing = 4;
`else
        spacing = 5;
`endif
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(spacing));
        waitIdle();

        issue(12'hC5A);
        waitIdle();
        saved = mMem[16];
        issue(12'h1F0);
        t = 0;
        while (!alu_en && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reached_q3", 32'(alu_en), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_alu_en", 32'(alu_en), 32'(0));
        chk("midrst_f_we", 32'(f_we), 32'(0));
        chk("midrst_w_reg", 32'(w_reg), 32'(0));
        chk("midrst_status", 32'(status_reg), 32'(0));
        mW = 8'h00; mSt = 3'b000; mMem[16] = saved;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 32'(instr_ready), 32'(1));
        issue(12'h210);
        waitIdle();
        chk("postrst_file_kept", 32'(w_reg), 32'(saved));

        chk("stray_f_we", 32'(strayWe), 32'(0));
        chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
